// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Purpose  : Decoupling FIFO between instruction fetch and decode (RV32).  |
// |            Captures {instr, PC, PC+4} from fetch and presents the oldest |
// |            entry to decode with a valid/ready handshake. Back-pressures  |
// |            fetch when full and discards everything on a redirect flush.  |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            f_valid/f_ready, f_instr, f_pc, f_pcplus4  - fetch side       |
// |            flush                                      - redirect         |
// |            d_valid/d_ready, d_instr, d_pc, d_pcplus4  - decode side      |
// |            level                                      - occupancy        |
// |            stall_cnt, flush_cnt                       - stats (optional) |
// | Config   : IFQ_STATS_EN - adds saturating stall_cnt / flush_cnt outputs  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [XLEN-1:0]            f_instr,
  input  logic [XLEN-1:0]            f_pc,
  input  logic [XLEN-1:0]            f_pcplus4,
  input  logic                       flush,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [XLEN-1:0]            d_instr,
  output logic [XLEN-1:0]            d_pc,
  output logic [XLEN-1:0]            d_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Storage carries no reset; validity is tracked solely by level_q.
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc4_q   [DEPTH];

  logic push;
  logic pop;

  // Handshake is derived from registered occupancy only, so f_ready never
  // depends on d_ready (no combinational path across the queue).
  always_comb begin
    f_ready = (level_q != FULL_LVL);
    d_valid = (level_q != '0);
    push    = f_valid & f_ready;
    pop     = d_valid & d_ready;
  end

  // Next-state: flush overrides any concurrent push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_q[wr_ptr_q] <= f_instr;
      pc_q[wr_ptr_q]    <= f_pc;
      pc4_q[wr_ptr_q]   <= f_pcplus4;
    end
  end

  // Head entry is a pure mux of storage, so it holds steady while decode stalls.
  always_comb begin
    d_instr   = NOP;
    d_pc      = '0;
    d_pcplus4 = '0;
    if (d_valid) begin
      d_instr   = instr_q[rd_ptr_q];
      d_pc      = pc_q[rd_ptr_q];
      d_pcplus4 = pc4_q[rd_ptr_q];
    end
    level = level_q;
  end

`ifdef IFQ_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters; flush only counts, it never clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (f_valid && !f_ready && !flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  always_comb begin
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_queue                                                |
// | Purpose  : Self-checking bench for fetch_queue: directed scenarios with  |
// |            literal expectations plus randomized traffic against a queue  |
// |            based reference model.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, f_ready, flush, d_valid, d_ready;
  logic [31:0] f_instr, f_pc, f_pcplus4, d_instr, d_pc, d_pcplus4;
  logic [1:0]  level;
`ifdef IFQ_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall, m_flush;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_instr   (f_instr),
    .f_pc      (f_pc),
    .f_pcplus4 (f_pcplus4),
    .flush     (flush),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .d_pcplus4 (d_pcplus4),
    .level     (level)
`ifdef IFQ_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t mq[$];

  // Reference model: a plain FIFO of entries, updated from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
`ifdef IFQ_STATS_EN
      m_stall = 0;
      m_flush = 0;
`endif
    end else begin
      bit   can_push, can_pop;
      ent_t e;
      can_push = f_valid && (mq.size() < DEPTH);
      can_pop  = d_ready && (mq.size() > 0);
`ifdef IFQ_STATS_EN
      if (f_valid && mq.size() == DEPTH && !flush) m_stall++;
      if (flush) m_flush++;
`endif
      if (flush) begin
        mq.delete();
      end else begin
        if (can_pop) void'(mq.pop_front());
        if (can_push) begin
          e.instr = f_instr;
          e.pc    = f_pc;
          e.pc4   = f_pcplus4;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] e_instr, e_pc, e_pc4;
    e_instr = NOP;
    e_pc    = 32'h0;
    e_pc4   = 32'h0;
    if (mq.size() > 0) begin
      e_instr = mq[0].instr;
      e_pc    = mq[0].pc;
      e_pc4   = mq[0].pc4;
    end
    chk("m_level",   {30'd0, level},   32'(mq.size()));
    chk("m_f_ready", {31'd0, f_ready}, {31'd0, mq.size() != DEPTH});
    chk("m_d_valid", {31'd0, d_valid}, {31'd0, mq.size() != 0});
    chk("m_d_instr", d_instr,   e_instr);
    chk("m_d_pc",    d_pc,      e_pc);
    chk("m_d_pc4",   d_pcplus4, e_pc4);
`ifdef IFQ_STATS_EN
    chk("m_stall_cnt", stall_cnt, m_stall);
    chk("m_flush_cnt", flush_cnt, m_flush);
`endif
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    f_valid   = v;
    f_pc      = pc;
    f_pcplus4 = pc + 32'd4;
    f_instr   = 32'h00000093 | (pc << 18);
    d_ready   = rdy;
    flush     = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_d_instr", d_instr, 32'h00000013);
    chk("rst_level",   {30'd0, level}, 32'd0);
    chk("rst_f_ready", {31'd0, f_ready}, 32'd1);
    rst_n = 1'b1;

    // Single push, one-cycle latency
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    f_instr = 32'h00500093;
    @(negedge clk);
    f_valid = 1'b0;
    chk("push_d_valid", {31'd0, d_valid}, 32'd1);
    chk("push_d_instr", d_instr, 32'h00500093);
    chk("push_d_pc",    d_pc, 32'h0);
    chk("push_d_pc4",   d_pcplus4, 32'h4);
    chk("push_level",   {30'd0, level}, 32'd1);

    // Fill, then hold f_valid while full
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_level",   {30'd0, level}, 32'd2);
    chk("fill_f_ready", {31'd0, f_ready}, 32'd0);
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_level", {30'd0, level}, 32'd2);
    chk("hold_d_pc",  d_pc, 32'h0);
`ifdef IFQ_STATS_EN
    chk("hold_stall_cnt", stall_cnt, 32'd1);
`endif

    // Full + d_ready: pop only, then order preserved across pointer wrap
    d_ready = 1'b1;
    @(negedge clk);
    chk("popfull_level", {30'd0, level}, 32'd1);
    chk("popfull_d_pc",  d_pc, 32'h4);
    @(negedge clk);
    chk("wrap_level", {30'd0, level}, 32'd1);
    chk("wrap_d_pc",  d_pc, 32'h8);
    f_valid = 1'b0;
    @(negedge clk);
    chk("drain_level",   {30'd0, level}, 32'd0);
    chk("drain_d_valid", {31'd0, d_valid}, 32'd0);

    // Flush beats concurrent push and pop
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    @(negedge clk);
    chk("preflush_level", {30'd0, level}, 32'd2);
    drive(1'b1, 32'h18, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_level",   {30'd0, level}, 32'd0);
    chk("flush_d_valid", {31'd0, d_valid}, 32'd0);
    chk("flush_f_ready", {31'd0, f_ready}, 32'd1);
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge clk);
    chk("postflush_d_pc", d_pc, 32'h40);

    // Steady stream: one in, one out per cycle
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h44 + 32'(4 * k), 1'b1, 1'b0);
      @(negedge clk);
      chk("stream_level", {30'd0, level}, 32'd1);
      chk("stream_d_pc",  d_pc, 32'h44 + 32'(4 * k));
    end

    // Asynchronous reset mid-stream acts without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_level",   {30'd0, level}, 32'd0);
    chk("async_d_valid", {31'd0, d_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      f_valid   = ($urandom_range(0, 3) != 0);
      d_ready   = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      f_instr   = $urandom;
      f_pc      = $urandom;
      f_pcplus4 = f_pc + 32'd4;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
